ifetch_seq: RTL and testbench

//  Instruction fetch sequencer directly upstream of the instruction ROM (irom). Owns the program

---
 rtl/ifetch_seq_if.sv | 27 ++
 rtl/ifetch_seq.sv | 97 +++++++++
 tb/tb_ifetch_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_seq_if.sv
// Fetch-side bundle: irom request/response, redirect/halt control and the decode-facing queue head.
interface ifetch_seq_if #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned AWIDTH = 12
);
    logic [AWIDTH-1:0] rom_addr;
    logic              rom_ready;
    logic [DWIDTH-1:0] rom_dout;
    logic              rom_valid;
    logic              redirect;
    logic [AWIDTH-1:0] redirect_pc;
    logic              halt;
    logic [DWIDTH-1:0] ins_out;
    logic [AWIDTH-1:0] ins_pc;
    logic              ins_valid;
    logic              ins_ready;

    modport master (
        output rom_addr, rom_ready, ins_out, ins_pc, ins_valid,
        input  rom_dout, rom_valid, redirect, redirect_pc, halt, ins_ready
    );

    modport slave (
        input  rom_addr, rom_ready, ins_out, ins_pc, ins_valid,
        output rom_dout, rom_valid, redirect, redirect_pc, halt, ins_ready
    );
endinterface

// File: rtl/ifetch_seq.sv
// Instruction fetch sequencer: owns the PC, issues irom reads under a credit limit and queues
// {pc, instr} pairs toward decode; supports redirect (flush), halt and PC wrap-around.
module ifetch_seq #(
    parameter int unsigned DWIDTH     = 16,
    parameter int unsigned AWIDTH     = 12,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    ifetch_seq_if.master bus
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;

    logic [AWIDTH-1:0] r_pc;
    logic [AWIDTH-1:0] r_req_pc;
    logic              r_run;
    logic [DWIDTH-1:0] r_mem_ins [FIFO_DEPTH];
    logic [AWIDTH-1:0] r_mem_pc  [FIFO_DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [SW-1:0]     w_credit_used;

    // Credit: queued entries plus the single in-flight response must fit in the FIFO.
    always_comb begin
        w_credit_used = SW'(r_count) + SW'(bus.rom_valid);
        w_empty       = (r_count == '0);
        w_issue       = r_run && !bus.redirect && !bus.halt && (w_credit_used < SW'(FIFO_DEPTH));
        w_push        = bus.rom_valid && !bus.redirect;
        w_pop         = !w_empty && bus.ins_ready && !bus.redirect;
    end

    assign bus.rom_addr  = r_pc;
    assign bus.rom_ready = w_issue;
    assign bus.ins_valid = !w_empty;
    assign bus.ins_out   = w_empty ? '0 : r_mem_ins[r_rptr];
    assign bus.ins_pc    = w_empty ? '0 : r_mem_pc[r_rptr];

    // PC, request tracking and FIFO bookkeeping; redirect overrides everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run    <= 1'b0;
            r_pc     <= AWIDTH'(RESET_PC);
            r_req_pc <= AWIDTH'(RESET_PC);
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
        end else begin
            r_run <= 1'b1;
            if (bus.redirect) begin
                r_pc <= bus.redirect_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + AWIDTH'(1);
            end
            if (w_issue) begin
                r_req_pc <= r_pc;
            end
            if (bus.redirect) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + PW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Payload storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_ins[r_wptr] <= bus.rom_dout;
            r_mem_pc[r_wptr]  <= r_req_pc;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && (r_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_ifetch_seq.sv
// Directed bench for ifetch_seq with a behavioural 1-cycle irom returning mem[a] = a + 0x100.
module tb_ifetch_seq;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 12;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [AW-1:0] iss_q[$];
    logic [AW-1:0] dpc_q[$];
    logic [DW-1:0] dins_q[$];

    ifetch_seq_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    ifetch_seq #(.DWIDTH(DW), .AWIDTH(AW), .FIFO_DEPTH(2), .RESET_PC(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // irom model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rom_valid <= 1'b0;
            bus.rom_dout  <= '0;
        end else begin
            bus.rom_valid <= bus.rom_ready;
            if (bus.rom_ready) bus.rom_dout <= DW'(bus.rom_addr) + 16'h0100;
        end
    end

    // Log issued addresses and accepted instructions mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rom_ready) iss_q.push_back(bus.rom_addr);
            if (bus.ins_valid && bus.ins_ready && !bus.redirect) begin
                dpc_q.push_back(bus.ins_pc);
                dins_q.push_back(bus.ins_out);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        iss_q.delete();
        dpc_q.delete();
        dins_q.delete();
    endtask

    task automatic do_reset();
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;
        bus.ins_ready   = 1'b0;
        rst_n           = 1'b0;
        step(2);
        rst_n = 1'b1;
        clear_q();
    endtask

    task automatic test_reset();
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.halt = 1'b0; bus.ins_ready = 1'b1;
        rst_n = 1'b0;
        step(2);
        n_tests++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ins_valid got %0b exp 0", bus.ins_valid); end
        n_tests++; if (bus.rom_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rom_ready got %0b exp 0", bus.rom_ready); end
        n_tests++; if (bus.rom_addr !== 12'h000) begin n_fail++; $display("FAIL reset_rom_addr got %h exp 000", bus.rom_addr); end
        n_tests++; if (bus.ins_out !== 16'h0000) begin n_fail++; $display("FAIL reset_ins_out got %h exp 0000", bus.ins_out); end
        n_tests++; if (bus.ins_pc !== 12'h000) begin n_fail++; $display("FAIL reset_ins_pc got %h exp 000", bus.ins_pc); end
    endtask

    task automatic test_stream();
        do_reset();
        bus.ins_ready = 1'b1;
        #1;
        n_tests++; if (bus.rom_ready !== 1'b0) begin n_fail++; $display("FAIL stream_release_ready got %0b exp 0", bus.rom_ready); end
        step(1);
        n_tests++; if (bus.rom_ready !== 1'b1 || bus.rom_addr !== 12'h000) begin n_fail++; $display("FAIL stream_first_req got rdy=%0b addr=%h exp rdy=1 addr=000", bus.rom_ready, bus.rom_addr); end
        step(1);
        n_tests++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("FAIL stream_lat1 got ins_valid=%0b exp 0", bus.ins_valid); end
        step(1);
        n_tests++; if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 12'h000 || bus.ins_out !== 16'h0100) begin n_fail++; $display("FAIL stream_lat2 got v=%0b pc=%h ins=%h exp v=1 pc=000 ins=0100", bus.ins_valid, bus.ins_pc, bus.ins_out); end
        step(30);
        n_tests++;
        if (iss_q.size() < 8 || dpc_q.size() < 8) begin
            n_fail++; $display("FAIL stream_count got iss=%0d deliv=%0d exp >=8 each", iss_q.size(), dpc_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++; if (iss_q[i] !== 12'(i)) begin n_fail++; $display("FAIL stream_addr[%0d] got %h exp %h", i, iss_q[i], 12'(i)); end
                n_tests++; if (dpc_q[i] !== 12'(i) || dins_q[i] !== 16'h0100 + 16'(i)) begin n_fail++; $display("FAIL stream_deliv[%0d] got pc=%h ins=%h exp pc=%h ins=%h", i, dpc_q[i], dins_q[i], 12'(i), 16'h0100 + 16'(i)); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        step(10);
        n_tests++; if (iss_q.size() != 2) begin n_fail++; $display("FAIL bp_issue_count got %0d exp 2", iss_q.size()); end
        n_tests++; if (bus.rom_ready !== 1'b0) begin n_fail++; $display("FAIL bp_rom_ready got %0b exp 0", bus.rom_ready); end
        n_tests++; if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 12'h000 || bus.ins_out !== 16'h0100) begin n_fail++; $display("FAIL bp_head got v=%0b pc=%h ins=%h exp v=1 pc=000 ins=0100", bus.ins_valid, bus.ins_pc, bus.ins_out); end
        bus.ins_ready = 1'b1;
        step(24);
        n_tests++;
        if (dpc_q.size() < 8) begin
            n_fail++; $display("FAIL bp_deliv_count got %0d exp >=8", dpc_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++; if (dpc_q[i] !== 12'(i) || dins_q[i] !== 16'h0100 + 16'(i)) begin n_fail++; $display("FAIL bp_deliv[%0d] got pc=%h ins=%h exp pc=%h ins=%h", i, dpc_q[i], dins_q[i], 12'(i), 16'h0100 + 16'(i)); end
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        step(3);
        n_tests++; if (bus.ins_valid !== 1'b1) begin n_fail++; $display("FAIL redir_pre_valid got %0b exp 1", bus.ins_valid); end
        bus.redirect = 1'b1; bus.redirect_pc = 12'h040;
        clear_q();
        #1;
        n_tests++; if (bus.rom_ready !== 1'b0) begin n_fail++; $display("FAIL redir_rom_ready got %0b exp 0", bus.rom_ready); end
        step(1);
        bus.redirect = 1'b0; bus.ins_ready = 1'b1;
        #1;
        n_tests++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush got ins_valid=%0b exp 0", bus.ins_valid); end
        n_tests++; if (bus.rom_addr !== 12'h040 || bus.rom_ready !== 1'b1) begin n_fail++; $display("FAIL redir_resume got addr=%h rdy=%0b exp addr=040 rdy=1", bus.rom_addr, bus.rom_ready); end
        step(20);
        n_tests++;
        if (dpc_q.size() < 6) begin
            n_fail++; $display("FAIL redir_deliv_count got %0d exp >=6", dpc_q.size());
        end else begin
            for (int i = 0; i < dpc_q.size(); i++) begin
                n_tests++; if (dpc_q[i] !== 12'h040 + 12'(i) || dins_q[i] !== 16'h0140 + 16'(i)) begin n_fail++; $display("FAIL redir_deliv[%0d] got pc=%h ins=%h exp pc=%h ins=%h", i, dpc_q[i], dins_q[i], 12'h040 + 12'(i), 16'h0140 + 16'(i)); end
            end
        end
    endtask

    task automatic test_wrap();
        bus.ins_ready = 1'b1;
        bus.redirect = 1'b1; bus.redirect_pc = 12'hFFE;
        clear_q();
        step(1);
        bus.redirect = 1'b0;
        step(15);
        n_tests++;
        if (dpc_q.size() < 4) begin
            n_fail++; $display("FAIL wrap_deliv_count got %0d exp >=4", dpc_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                logic [AW-1:0] epc;
                logic [DW-1:0] eins;
                epc  = 12'hFFE + 12'(i);
                eins = DW'(epc) + 16'h0100;
                n_tests++; if (dpc_q[i] !== epc || dins_q[i] !== eins) begin n_fail++; $display("FAIL wrap_deliv[%0d] got pc=%h ins=%h exp pc=%h ins=%h", i, dpc_q[i], dins_q[i], epc, eins); end
            end
        end
    endtask

    task automatic test_halt();
        bus.ins_ready = 1'b1;
        bus.redirect = 1'b1; bus.redirect_pc = 12'h200;
        clear_q();
        step(1);
        bus.redirect = 1'b0;
        step(10);
        bus.halt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_tests++; if (bus.rom_ready !== 1'b0) begin n_fail++; $display("FAIL halt_rom_ready[%0d] got %0b exp 0", k, bus.rom_ready); end
            step(1);
        end
        n_tests++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("FAIL halt_drained got ins_valid=%0b exp 0", bus.ins_valid); end
        bus.halt = 1'b0;
        #1;
        n_tests++; if (bus.rom_ready !== 1'b1) begin n_fail++; $display("FAIL halt_release got rom_ready=%0b exp 1", bus.rom_ready); end
        step(15);
        n_tests++;
        if (dpc_q.size() < 10) begin
            n_fail++; $display("FAIL halt_deliv_count got %0d exp >=10", dpc_q.size());
        end else begin
            for (int i = 0; i < dpc_q.size(); i++) begin
                n_tests++; if (dpc_q[i] !== 12'h200 + 12'(i) || dins_q[i] !== 16'h0300 + 16'(i)) begin n_fail++; $display("FAIL halt_deliv[%0d] got pc=%h ins=%h exp pc=%h ins=%h", i, dpc_q[i], dins_q[i], 12'h200 + 12'(i), 16'h0300 + 16'(i)); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        bus.ins_ready = 1'b0;
        bus.redirect = 1'b1; bus.redirect_pc = 12'h300;
        step(1);
        bus.redirect = 1'b0;
        step(6);
        n_tests++; if (bus.ins_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid got %0b exp 1", bus.ins_valid); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.ins_valid !== 1'b0 || bus.rom_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_async got v=%0b rdy=%0b exp v=0 rdy=0", bus.ins_valid, bus.rom_ready); end
        step(1);
        rst_n = 1'b1;
        bus.ins_ready = 1'b1;
        clear_q();
        step(25);
        n_tests++;
        if (iss_q.size() < 1 || dpc_q.size() < 6) begin
            n_fail++; $display("FAIL rstmid_count got iss=%0d deliv=%0d exp >=1 and >=6", iss_q.size(), dpc_q.size());
        end else begin
            n_tests++; if (iss_q[0] !== 12'h000) begin n_fail++; $display("FAIL rstmid_first_addr got %h exp 000", iss_q[0]); end
            for (int i = 0; i < 6; i++) begin
                n_tests++; if (dpc_q[i] !== 12'(i) || dins_q[i] !== 16'h0100 + 16'(i)) begin n_fail++; $display("FAIL rstmid_deliv[%0d] got pc=%h ins=%h exp pc=%h ins=%h", i, dpc_q[i], dins_q[i], 12'(i), 16'h0100 + 16'(i)); end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
